calc1_req_driver: RTL and testbench
===================================

# calc1_req_driver

Per-port request driver sitting directly upstream of one calc1 request port (reqN_cmd_in/reqN_data_in) and consuming that port's response (out_respN/out_dataN). It accepts a complete operation (command, operand 1, operand 2) in one valid/ready handshake and serialises it into calc1's two-cycle protocol. It then waits for calc1's response, with a timeout, and holds the result on a valid/ready response interface. Four instances, one per calc1 port, form the stimulus/issue layer for directed and random benches.

## Interface
- TIMEOUT_CYCLES, 64: WAIT cycles without a non-zero calc1 response before the request is abandoned; legal range 1..255.
- c_clk  in  1  clock; all logic on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- req_valid  in  1  operation request present
- req_ready  out  1  driver can accept a request
- req_cmd  in  4  calc1 command (0 no-op, 1 add, 2 sub, 5 shl, 6 shr; others forwarded unchanged)
- req_op1  in  32  operand 1
- req_op2  in  32  operand 2 (shift amount for 5/6)
- calc_cmd  out  4  to calc1 reqN_cmd_in
- calc_data  out  32  to calc1 reqN_data_in
- calc_resp  in  2  from calc1 out_respN (0 none, 1 success, 2 overflow/underflow/invalid, 3 internal error)
- calc_rdata  in  32  from calc1 out_dataN
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_code  out  2  captured calc_resp
- rsp_data  out  32  captured calc_rdata
- rsp_timeout  out  1  result is a timeout, not a calc1 response

## Operation
- States: IDLE, SEND1, SEND2, WAIT, HOLD.
- IDLE: req_ready=1. On req_valid, latch cmd/op1/op2.
  - cmd=0: go to HOLD with rsp_code=0, rsp_data=0, rsp_timeout=0. calc1 is not driven.
  - cmd≠0: go to SEND1.
- SEND1: calc_cmd=latched cmd, calc_data=op1. Go to SEND2.
- SEND2: calc_cmd=0, calc_data=op2. Go to WAIT and clear the timeout counter.
- WAIT: calc_cmd=0, calc_data=0. Sample calc_resp every cycle.
  - First cycle with calc_resp≠0: capture calc_resp and calc_rdata, then go to HOLD.
  - Counter reaches TIMEOUT_CYCLES: go to HOLD with rsp_code=0, rsp_data=0, rsp_timeout=1.
- HOLD: rsp_valid=1. rsp_code, rsp_data and rsp_timeout stay stable until rsp_valid&rsp_ready, then go to IDLE.
- A non-zero calc_resp in any state other than WAIT is ignored. It is not captured and is not an error.
- Invalid commands (3, 4, 7..15) still get the full two-cycle sequence. Checking them is calc1's job.
- The counter is 8 bits and saturates; it never wraps.

## Timing
- Reset values: req_ready=0 during reset and 1 in the first cycle after it. calc_cmd=0, calc_data=0, rsp_valid=0, rsp_code=0, rsp_data=0, rsp_timeout=0. State = IDLE.
- Reset asserted in any state: the next edge forces IDLE and all outputs to their reset values. A request already in flight is dropped without a response.
- All outputs are registered. There is no combinational path from any input to any output.
- Handshake timing for a request accepted at edge N:
  - calc_cmd/op1 are driven in cycle N+1 and op2 in cycle N+2.
  - WAIT starts at N+3.
  - A response sampled at edge M shows rsp_valid from M+1.
- Zero-latency acceptance is not provided. req_ready is deasserted from the acceptance edge until HOLD completes.
- Minimum spacing between accepted requests is 5 cycles. A cmd=0 request takes 2 cycles (IDLE, HOLD).
- rsp_ready held low: the driver stays in HOLD indefinitely, req_ready stays 0, calc_cmd stays 0.

## Structure
- Shared package calc1_pkg holds:
  - command codes (CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR) and response codes (RSP_NONE, RSP_OK, RSP_ERR, RSP_INTERNAL);
  - the driver state enum;
  - the operand width constant (32).
- Single flat module; no sub-module needed. The timeout counter is a few lines inline.

## Test plan
- Add 1 + 0x1FFFFFFF, with calc1 returning resp 1 and 0x20000000 four cycles after op2:
  - calc_cmd=1/calc_data=0x00000001 in SEND1;
  - calc_cmd=0/calc_data=0x1FFFFFFF in SEND2;
  - rsp_code=1, rsp_data=0x20000000, rsp_timeout=0.
- Add 0xFFFFFFFF + 1 → rsp_code=2, rsp_data=0x00000000.
- Sub 1 − 0xF → rsp_code=2, rsp_data=0x00000000.
- Invalid cmd 3 with op1=1 → two-cycle issue seen on calc_cmd/calc_data; rsp_code=2.
- TIMEOUT_CYCLES=8 and calc_resp held at 0 → rsp_valid exactly 9 cycles after SEND2, with rsp_timeout=1 and rsp_code=0.
- rsp_ready low for 10 cycles after rsp_valid → rsp_* stable and req_ready=0 throughout. Raise rsp_ready → req_ready=1 on the next cycle.
- Reset asserted in the 2nd WAIT cycle, followed by calc_resp=1 → no rsp_valid, all outputs 0. A new cmd=0 request completes in 2 cycles with rsp_code=0.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared definitions for calc1 and the logic around it:
// command codes, response codes, driver states and the operand width.
package calc1_pkg;

    localparam int OPERAND_W = 32;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RSP_NONE     = 2'd0;
    localparam logic [1:0] RSP_OK       = 2'd1;
    localparam logic [1:0] RSP_ERR      = 2'd2;
    localparam logic [1:0] RSP_INTERNAL = 2'd3;

    typedef enum logic [2:0] {
        DRV_IDLE,
        DRV_SEND1,
        DRV_SEND2,
        DRV_WAIT,
        DRV_HOLD
    } drv_state_e;

endpackage

// File: rtl/calc1_req_driver.sv
// Per-port calc1 request driver: takes one whole operation, issues it over
// calc1's two-cycle request protocol, waits (with timeout) and holds the result.
module calc1_req_driver
    import calc1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 c_clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_cmd,
    input  logic [OPERAND_W-1:0] req_op1,
    input  logic [OPERAND_W-1:0] req_op2,
    output logic [3:0]           calc_cmd,
    output logic [OPERAND_W-1:0] calc_data,
    input  logic [1:0]           calc_resp,
    input  logic [OPERAND_W-1:0] calc_rdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_code,
    output logic [OPERAND_W-1:0] rsp_data,
    output logic                 rsp_timeout
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    drv_state_e           state_q, state_d;
    logic [OPERAND_W-1:0] op2_q, op2_d;
    logic [7:0]           cnt_q, cnt_d, cnt_inc;
    logic                 req_ready_d, rsp_valid_d, rsp_timeout_d;
    logic [3:0]           calc_cmd_d;
    logic [OPERAND_W-1:0] calc_data_d, rsp_data_d;
    logic [1:0]           rsp_code_d;

    // Every output is computed here for the *next* cycle and registered below,
    // so no input ever reaches an output combinationally.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        op2_d         = op2_q;
        cnt_d         = cnt_q;
        cnt_inc       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        req_ready_d   = 1'b0;
        calc_cmd_d    = CMD_NOP;
        calc_data_d   = '0;
        rsp_valid_d   = 1'b0;
        rsp_code_d    = rsp_code;
        rsp_data_d    = rsp_data;
        rsp_timeout_d = rsp_timeout;

        case (state_q)
            DRV_IDLE: begin
                if (req_ready && req_valid) begin
                    op2_d = req_op2;
                    if (req_cmd == CMD_NOP) begin
                        state_d       = DRV_HOLD;
                        rsp_valid_d   = 1'b1;
                        rsp_code_d    = RSP_NONE;
                        rsp_data_d    = '0;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d     = DRV_SEND1;
                        calc_cmd_d  = req_cmd;
                        calc_data_d = req_op1;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            DRV_SEND1: begin
                state_d     = DRV_SEND2;
                calc_data_d = op2_q;
            end
            DRV_SEND2: begin
                state_d = DRV_WAIT;
                cnt_d   = '0;
            end
            DRV_WAIT: begin
                if (calc_resp != RSP_NONE) begin
                    state_d       = DRV_HOLD;
                    rsp_valid_d   = 1'b1;
                    rsp_code_d    = calc_resp;
                    rsp_data_d    = calc_rdata;
                    rsp_timeout_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TIMEOUT_LIM) begin
                        state_d       = DRV_HOLD;
                        rsp_valid_d   = 1'b1;
                        rsp_code_d    = RSP_NONE;
                        rsp_data_d    = '0;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            DRV_HOLD: begin
                if (rsp_ready) begin
                    state_d     = DRV_IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = DRV_IDLE;
        endcase
    end

    always_ff @(posedge c_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= DRV_IDLE;
            op2_q       <= '0;
            cnt_q       <= '0;
            req_ready   <= 1'b0;
            calc_cmd    <= CMD_NOP;
            calc_data   <= '0;
            rsp_valid   <= 1'b0;
            rsp_code    <= RSP_NONE;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            op2_q       <= op2_d;
            cnt_q       <= cnt_d;
            req_ready   <= req_ready_d;
            calc_cmd    <= calc_cmd_d;
            calc_data   <= calc_data_d;
            rsp_valid   <= rsp_valid_d;
            rsp_code    <= rsp_code_d;
            rsp_data    <= rsp_data_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_calc1_req_driver.sv
// Self-checking bench for calc1_req_driver: directed cases plus random
// operations against a transaction-level model of calc1 and the driver.
module tb_calc1_req_driver;
    import calc1_pkg::*;

    localparam int TMO = 8;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_op1, req_op2;
    logic [3:0]  calc_cmd;
    logic [31:0] calc_data;
    logic [1:0]  calc_resp;
    logic [31:0] calc_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    logic        rsp_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    calc1_req_driver #(.TIMEOUT_CYCLES(TMO)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
        .calc_cmd(calc_cmd), .calc_data(calc_data),
        .calc_resp(calc_resp), .calc_rdata(calc_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_code(rsp_code), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got running, required done)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // What calc1 answers for an operation: {code, data}.
    function automatic logic [33:0] calc1_model(input logic [3:0] cmd,
                                                input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        case (cmd)
            CMD_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                calc1_model = sum[32] ? {RSP_ERR, 32'd0} : {RSP_OK, sum[31:0]};
            end
            CMD_SUB: calc1_model = (a < b) ? {RSP_ERR, 32'd0} : {RSP_OK, a - b};
            CMD_SHL: calc1_model = {RSP_OK, a << b[4:0]};
            CMD_SHR: calc1_model = {RSP_OK, a >> b[4:0]};
            default: calc1_model = {RSP_ERR, 32'd0};
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_calc_cmd"},  calc_cmd, 0);
        check({tag, "_calc_data"}, calc_data, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_code"},  rsp_code, 0);
        check({tag, "_rsp_data"},  rsp_data, 0);
        check({tag, "_rsp_tmo"},   rsp_timeout, 0);
    endtask

    // One operation end to end. calc1 answers with code/rdata in WAIT cycle
    // 'dly' (0-based); dly >= TMO means it never answers.
    task automatic run_req(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                           input int dly, input int hold_low,
                           input logic [1:0] code, input logic [31:0] rdata);
        logic        got;
        logic [1:0]  exp_code;
        logic [31:0] exp_data;
        logic        exp_tmo;
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) step();
        check("req_ready_idle", req_ready, 1);
        rsp_ready = 1'b0;
        calc_resp = RSP_NONE;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_op1   = op1;
        req_op2   = op2;
        step();
        req_valid = 1'b0;
        req_cmd   = 4'($urandom);
        req_op1   = $urandom;
        req_op2   = $urandom;
        exp_code  = RSP_NONE;
        exp_data  = 32'd0;
        exp_tmo   = 1'b0;
        if (cmd != CMD_NOP) begin
            check("send1_cmd", calc_cmd, cmd);
            check("send1_data", calc_data, op1);
            check("send1_ready", req_ready, 0);
            calc_resp  = 2'($urandom_range(1, 3));
            calc_rdata = $urandom;
            step();
            check("send2_cmd", calc_cmd, 0);
            check("send2_data", calc_data, op2);
            calc_resp = 2'($urandom_range(1, 3));
            step();
            got = 1'b0;
            for (int w = 0; w < TMO && !got; w++) begin
                check("wait_cmd", calc_cmd, 0);
                check("wait_data", calc_data, 0);
                check("wait_valid", rsp_valid, 0);
                if (w == dly) begin
                    calc_resp  = code;
                    calc_rdata = rdata;
                    got        = 1'b1;
                end else begin
                    calc_resp  = RSP_NONE;
                    calc_rdata = $urandom;
                end
                step();
            end
            if (dly < TMO) begin
                exp_code = code;
                exp_data = rdata;
            end else begin
                exp_tmo = 1'b1;
            end
        end
        for (int h = 0; h <= hold_low; h++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_code", rsp_code, exp_code);
            check("hold_data", rsp_data, exp_data);
            check("hold_tmo", rsp_timeout, exp_tmo);
            check("hold_req_ready", req_ready, 0);
            check("hold_calc_cmd", calc_cmd, 0);
            calc_resp  = 2'($urandom_range(1, 3));
            calc_rdata = $urandom;
            if (h == hold_low) rsp_ready = 1'b1;
            step();
        end
        rsp_ready = 1'b0;
        calc_resp = RSP_NONE;
        check("release_valid", rsp_valid, 0);
        check("release_req_ready", req_ready, 1);
    endtask

    task automatic run_op(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                          input int dly, input int hold_low);
        logic [33:0] r;
        r = calc1_model(cmd, op1, op2);
        run_req(cmd, op1, op2, dly, hold_low, r[33:32], r[31:0]);
    endtask

    initial begin
        logic [3:0]  cmd_tab [8];
        logic [3:0]  cmd;
        logic [33:0] r;
        cmd_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd9, 4'd15};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_cmd    = '0;
        req_op1    = '0;
        req_op2    = '0;
        calc_resp  = RSP_NONE;
        calc_rdata = '0;
        rsp_ready  = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        check("reset_req_ready", req_ready, 0);
        reset = 1'b0;
        step();
        check("post_reset_req_ready", req_ready, 1);

        run_op(CMD_ADD, 32'h0000_0001, 32'h1FFF_FFFF, 3, 0);
        run_op(CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2, 0);
        run_op(CMD_SUB, 32'h0000_0001, 32'h0000_000F, 0, 0);
        run_op(4'd3,    32'h0000_0001, 32'h0000_0002, 1, 0);
        run_op(CMD_SHL, 32'h0000_0003, 32'h0000_0004, 7, 0);
        run_op(CMD_ADD, 32'h0000_0005, 32'h0000_0006, 100, 0);
        run_op(CMD_SUB, 32'h0000_0009, 32'h0000_0004, 1, 10);
        run_op(CMD_NOP, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);

        // Reset while waiting for calc1 drops the request silently.
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) step();
        check("rst_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_cmd   = CMD_ADD;
        req_op1   = 32'd5;
        req_op2   = 32'd6;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset      = 1'b0;
        calc_resp  = RSP_OK;
        calc_rdata = 32'h0000_000B;
        check_idle_outputs("rst_wait");
        check("rst_wait_req_ready", req_ready, 0);
        step();
        calc_resp = RSP_NONE;
        check_idle_outputs("rst_after");
        check("rst_after_req_ready", req_ready, 1);
        run_op(CMD_NOP, 32'd0, 32'd0, 0, 0);

        for (int t = 0; t < 60; t++) begin
            cmd = cmd_tab[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) begin
                run_req(cmd, $urandom, $urandom, $urandom_range(0, 10), $urandom_range(0, 3),
                        RSP_INTERNAL, $urandom);
            end else begin
                run_op(cmd, $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
                       $urandom_range(0, 10), $urandom_range(0, 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
